// File: rtl/xilinx_sdp_width_conv_fifo.sv
// Single-clock narrow-to-wide packing FIFO on an inferred simple dual-port BRAM, FWFT read side.
// Optional WIDTH_CONV_FIFO_FLUSH_EN adds a flush input that commits a partially packed word.
module xilinx_sdp_width_conv_fifo #(
  parameter int unsigned C_WR_WIDTH           = 16,
  parameter int unsigned C_RATIO              = 2,
  parameter int unsigned C_RD_DEPTH           = 512,
  parameter int unsigned C_ALMOST_FULL_THRESH = C_RD_DEPTH - 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              wren,
  input  logic [C_WR_WIDTH-1:0]             din,
  output logic                              full,
  output logic                              almost_full,
  input  logic                              rden,
  output logic [C_WR_WIDTH*C_RATIO-1:0]     dout,
  output logic                              valid,
  output logic                              empty,
  output logic [$clog2(C_RD_DEPTH):0]       count,
`ifdef WIDTH_CONV_FIFO_FLUSH_EN
  input  logic                              flush,
`endif
  output logic                              overflow
);

  localparam int unsigned AW = $clog2(C_RD_DEPTH);
  localparam int unsigned RW = C_WR_WIDTH * C_RATIO;
  localparam int unsigned LW = (C_RATIO > 1) ? $clog2(C_RATIO) : 1;
  localparam logic [AW:0]   LP_DEPTH  = (AW+1)'(C_RD_DEPTH);
  localparam logic [AW:0]   LP_AF     = (AW+1)'(C_ALMOST_FULL_THRESH);
  localparam logic [LW-1:0] LP_LAST   = LW'(C_RATIO - 1);

  logic [RW-1:0]   r_mem [C_RD_DEPTH];
  logic [RW-1:0]   r_pack;
  logic [LW-1:0]   r_lane;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic [AW:0]     r_bram_cnt;
  logic [RW-1:0]   r_rdata;
  logic            r_pend;
  logic [RW-1:0]   r_dout;
  logic            r_valid;
  logic            r_overflow;

  logic            w_full;
  logic            w_accept;
  logic            w_commit;
  logic            w_pop;
  logic            w_load;
  logic            w_issue;
  logic [RW-1:0]   w_wdata;

  assign w_full   = (r_count == LP_DEPTH);
  assign w_accept = wren && !w_full;

`ifdef WIDTH_CONV_FIFO_FLUSH_EN
  // A flush commits whatever is packed, plus din if it is accepted on the same edge.
  assign w_commit = !w_full && ((wren && ((r_lane == LP_LAST) || flush)) ||
                                (flush && (r_lane != '0)));
`else
  assign w_commit = w_accept && (r_lane == LP_LAST);
`endif

  // Lanes below the counter come from the pack register, the current lane from din,
  // anything above stays zero (only reachable through a flush).
  always_comb begin
    w_wdata = '0;
    for (int i = 0; i < C_RATIO; i++) begin
      if (LW'(i) < r_lane) begin
        w_wdata[i*C_WR_WIDTH +: C_WR_WIDTH] = r_pack[i*C_WR_WIDTH +: C_WR_WIDTH];
      end else if ((LW'(i) == r_lane) && w_accept) begin
        w_wdata[i*C_WR_WIDTH +: C_WR_WIDTH] = din;
      end
    end
  end

  // Output stage is two deep: the BRAM output register (r_pend) and the dout register.
  assign w_pop   = rden && r_valid;
  assign w_load  = r_pend && (!r_valid || w_pop);
  assign w_issue = (r_bram_cnt != '0) && (!r_pend || w_load);

  always_ff @(posedge clk) begin
    if (w_commit) begin
      r_mem[r_wr_ptr] <= w_wdata;
    end
    if (w_issue) begin
      r_rdata <= r_mem[r_rd_ptr];
    end
    if (w_accept && !w_commit) begin
      for (int i = 0; i < C_RATIO; i++) begin
        if (LW'(i) == r_lane) begin
          r_pack[i*C_WR_WIDTH +: C_WR_WIDTH] <= din;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lane     <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_bram_cnt <= '0;
      r_pend     <= 1'b0;
      r_dout     <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_commit) begin
        r_lane   <= '0;
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end else if (w_accept) begin
        r_lane <= r_lane + 1'b1;
      end

      if (w_commit && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_commit && w_pop) begin
        r_count <= r_count - 1'b1;
      end

      if (w_commit && !w_issue) begin
        r_bram_cnt <= r_bram_cnt + 1'b1;
      end else if (!w_commit && w_issue) begin
        r_bram_cnt <= r_bram_cnt - 1'b1;
      end

      if (w_issue) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_pend   <= 1'b1;
      end else if (w_load) begin
        r_pend <= 1'b0;
      end

      if (w_load) begin
        r_dout  <= r_rdata;
        r_valid <= 1'b1;
      end else if (w_pop) begin
        r_valid <= 1'b0;
      end

      if (wren && w_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign full        = w_full;
  assign almost_full = (r_count >= LP_AF);
  assign dout        = r_dout;
  assign valid       = r_valid;
  assign empty       = !r_valid;
  assign count       = r_count;
  assign overflow    = r_overflow;

endmodule

// File: doc/xilinx_sdp_width_conv_fifo.md
# xilinx_sdp_width_conv_fifo

Single-clock, width-converting FIFO built on an inferred simple dual-port BRAM. Narrow words are packed into wide words of `C_RATIO` lanes and stored in the BRAM. The read side is first-word-fall-through (FWFT) with a registered output stage. It sits between narrow-producer datapaths (e.g. 16-bit pixel/weight streams) and wide-consumer engines, and replaces the two-clock RAM plus external packing glue when both sides share a clock.

## Interface
Parameters:
- `C_WR_WIDTH`, 16, width of one narrow input word.
- `C_RATIO`, 2, narrow words per wide word; power of two, ≥1. Read width = `C_WR_WIDTH*C_RATIO`.
- `C_RD_DEPTH`, 512, wide-word capacity; power of two, ≥2.
- `C_ALMOST_FULL_THRESH`, `C_RD_DEPTH-2`, `almost_full` asserts when `count >= C_ALMOST_FULL_THRESH`.

Ports (clock and reset first):
- `clk`, in, 1, single clock for all logic.
- `rst`, in, 1, synchronous, active-high reset.
- `wren`, in, 1, narrow write request.
- `din`, in, `C_WR_WIDTH`, narrow write data.
- `full`, out, 1, no narrow write accepted this cycle.
- `almost_full`, out, 1, occupancy threshold flag.
- `rden`, in, 1, pop the presented wide word.
- `dout`, out, `C_WR_WIDTH*C_RATIO`, FWFT wide data.
- `valid`, out, 1, `dout` holds a word.
- `empty`, out, 1, equals `!valid`.
- `count`, out, `clog2(C_RD_DEPTH)+1`, committed wide words not yet popped.
- `overflow`, out, 1, sticky; set by `wren` while `full`.

## Operation
- Packing: the pack register holds up to `C_RATIO-1` lanes and has a lane counter. The first accepted narrow word goes to lanes [`C_WR_WIDTH-1:0`]; later words fill successively higher lanes.
- Commit: on the accepting edge of the `C_RATIO`-th narrow word, {din, pack lanes} is written to BRAM[wrPtr]. On the same edge, `wrPtr` increments, the lane counter clears and `count` increments.
- If `C_RATIO==1`, every accepted word commits directly.
- Write accept: `wren && !full`.
- `full = (count == C_RD_DEPTH)`. A full FIFO blocks all narrow writes, including those into a partially filled pack register.
- A rejected write leaves all state unchanged and sets `overflow`.
- Prefetch: when the output stage is empty, or is being popped, and an unread committed word exists in BRAM, the block issues a BRAM read at `rdPtr` and increments `rdPtr`. The BRAM read is registered, and the result loads the output register on the next edge.
- Pop: `rden && valid` consumes `dout` and decrements `count`. `rden` while `!valid` is ignored (no underflow flag).
- A commit and a pop on the same edge leave `count` unchanged.
- `count` includes words that are in BRAM, in flight and in the output register. The BRAM therefore never holds more than `C_RD_DEPTH` unread entries and cannot overwrite unread data.
- Pointers are `clog2(C_RD_DEPTH)` bits and wrap naturally from `C_RD_DEPTH-1` to 0.
- Reset, including mid-packing or mid-read:
  - Clears pointers, lane counter, `count` and the output stage.
  - Partial pack contents are discarded.
  - BRAM contents are not cleared.

## Timing
- Reset values: `full=0`, `almost_full=0`, `valid=0`, `empty=1`, `dout=0`, `count=0`, `overflow=0`.
- Write-to-read latency on an empty FIFO: the commit edge is E. `valid=1` and `dout` are correct after edge E+2 (read issued at E+1, output register loaded at E+2).
- Back-to-back pops: with ≥2 words committed, `rden` held high gives one word per cycle with no bubbles. This needs prefetch to overlap the pop (the read is issued on the popping cycle).
- `full`, `almost_full` and `count` update on the commit/pop edge. They are registered, not combinational from `wren`/`rden`.
- `overflow` is set on the edge after the rejected `wren` and cleared only by `rst`.

## Configuration
- `WIDTH_CONV_FIFO_FLUSH_EN` defined: adds input port `flush` (1 bit).
  - `flush` with a non-empty pack register commits the partial word on that edge, unfilled upper lanes zero.
  - `flush` with `wren` accepted on the same edge includes `din` first, then commits.
  - `flush` with an empty pack register and no `wren` is a no-op.
  - `flush` while `full` is ignored and does not set `overflow` unless `wren` is also high.
- Not defined: no `flush` port. Partial words wait until `C_RATIO` lanes fill.

## Test plan
- Reset check: drive `rst` for 2 cycles -> all outputs at reset values. Write 0x0001 and 0x0002 (`C_RATIO=2`) -> `dout=0x00020001`, `valid` 2 cycles after the second write edge, `count=1`.
- Fill and overflow (`C_RD_DEPTH=4`): write 8 narrow words -> `full=1`, `count=4`. Write a 9th -> `overflow=1`, `count` stays 4. Pop all 4 -> data in order, then `empty=1`.
- Streaming: concurrent continuous `wren` and `rden` over 1000 words with random data -> scoreboard match, `count` never exceeds 4, no `valid` bubbles once ≥2 words are committed.
- Pointer wrap: 3 full fill/drain cycles at depth 4 -> order preserved across the wrap of `wrPtr` and `rdPtr`.
- Reset mid-pack: write 1 narrow word, assert `rst` -> write 0xAAAA, 0xBBBB -> `dout=0xBBBBAAAA`; the partial word is never seen.
- Flush (macro defined, `C_RATIO=4`): write 0x1111, then `flush` -> `dout=0x0000000000001111`. `flush` with `wren` of 0x2222 on the same edge -> `dout=0x0000000000002222`.
